// File: rtl/lbm_step_sequencer_if.sv
// ---------------------------------------------------------------------------
// lbm_step_sequencer_if
// Bundles the control traffic between the lattice-Boltzmann step sequencer
// and its surroundings (run control, divider handshake, RAM/register strobes).
//
// Handshake semantics (the only two exchanges on this bundle):
//   start/num_steps : single-cycle request, consumed only while busy=0; a
//                     request seen while busy=1 is dropped, never queued.
//   div_start/div_done : div_start is a one-cycle launch; the divider answers
//                     with div_done=1 for at least one cycle, and the
//                     sequencer only looks at div_done while it is waiting for
//                     that answer, so early or stale div_done pulses are
//                     harmless.
//
// Modports:
//   master : the sequencer (drives address, strobes, status).
//   slave  : the environment (drives start, num_steps, div_done).
// ---------------------------------------------------------------------------
interface lbm_step_sequencer_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int STEP_WIDTH    = 16
);
   logic                     start;
   logic [STEP_WIDTH-1:0]    num_steps;
   logic                     div_done;
   logic [ADDRESS_WIDTH-1:0] address;
   logic                     WE_p_mem;
   logic                     WE_ux_mem;
   logic                     WE_uy_mem;
   logic                     WE_fin_mem;
   logic                     select_init;
   logic                     LD_EN_P;
   logic                     LD_EN_PUX;
   logic                     LD_EN_PUY;
   logic                     div_start;
   logic                     busy;
   logic                     done;
   logic [STEP_WIDTH-1:0]    step_count;

   modport master (
      input  start, num_steps, div_done,
      output address, WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, select_init,
             LD_EN_P, LD_EN_PUX, LD_EN_PUY, div_start, busy, done, step_count
   );

   modport slave (
      output start, num_steps, div_done,
      input  address, WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, select_init,
             LD_EN_P, LD_EN_PUX, LD_EN_PUY, div_start, busy, done, step_count
   );
endinterface

// File: rtl/lbm_step_sequencer.sv
// ---------------------------------------------------------------------------
// lbm_step_sequencer
// Control FSM for one lattice-Boltzmann run: initialise every cell of the
// p/ux/uy/fin RAMs, then run num_steps moment sweeps. Each sweep visits every
// cell: read, load the moment registers, launch the divider, wait for it,
// write p/ux/uy back.
//
// Ports:
//   Clk       : single clock, rising edge.
//   Reset     : synchronous, active-low.
//   bus       : lbm_step_sequencer_if.master (start, num_steps, div_done in;
//               address, RAM write enables, select_init, moment load enables,
//               div_start, busy, done, step_count out).
//   state_dbg : current FSM state encoding, for observation only.
//
// All outputs are decoded from registers only (Moore), so no input reaches an
// output in the same cycle.
// ---------------------------------------------------------------------------
module lbm_step_sequencer #(
   parameter int GRID_DIM      = 256,
   parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
   parameter int STEP_WIDTH    = 16
) (
   input  logic                  Clk,
   input  logic                  Reset,
   lbm_step_sequencer_if.master  bus,
   output logic [3:0]            state_dbg
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      INIT_WR  = 4'd1,
      MOM_RD   = 4'd2,
      MOM_LD   = 4'd3,
      DIV_REQ  = 4'd4,
      DIV_WAIT = 4'd5,
      MOM_WR   = 4'd6,
      STEP_END = 4'd7,
      DONE     = 4'd8
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(GRID_DIM - 1);

   state_t                  state_q,      state_d;
   logic [ADDRESS_WIDTH-1:0] address_q,   address_d;
   logic [STEP_WIDTH-1:0]    step_count_q, step_count_d;
   logic [STEP_WIDTH-1:0]    num_steps_q,  num_steps_d;

   // Step count after the sweep that is finishing in STEP_END.
   logic [STEP_WIDTH-1:0]    step_count_inc;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q      <= IDLE;
         address_q    <= '0;
         step_count_q <= '0;
         num_steps_q  <= '0;
      end else begin
         state_q      <= state_d;
         address_q    <= address_d;
         step_count_q <= step_count_d;
         num_steps_q  <= num_steps_d;
      end
   end

   // Next-state logic. num_steps is captured once in IDLE, so later changes
   // on the input (or further start pulses) cannot disturb a run.
   always_comb begin
      state_d        = state_q;
      address_d      = address_q;
      step_count_d   = step_count_q;
      num_steps_d    = num_steps_q;
      step_count_inc = step_count_q + STEP_WIDTH'(1);

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               num_steps_d  = bus.num_steps;
               address_d    = '0;
               step_count_d = '0;
               state_d      = INIT_WR;
            end
         end
         INIT_WR: begin
            if (address_q == LAST_ADDR) begin
               address_d = '0;
               state_d   = (num_steps_q != '0) ? MOM_RD : DONE;
            end else begin
               address_d = address_q + ADDRESS_WIDTH'(1);
            end
         end
         MOM_RD:   state_d = MOM_LD;   // RAM read latency slot
         MOM_LD:   state_d = DIV_REQ;
         DIV_REQ:  state_d = DIV_WAIT;
         DIV_WAIT: begin
            if (bus.div_done) begin
               state_d = MOM_WR;
            end
         end
         MOM_WR: begin
            if (address_q == LAST_ADDR) begin
               address_d = '0;
               state_d   = STEP_END;
            end else begin
               address_d = address_q + ADDRESS_WIDTH'(1);
               state_d   = MOM_RD;
            end
         end
         STEP_END: begin
            step_count_d = step_count_inc;
            state_d      = (step_count_inc == num_steps_q) ? DONE : MOM_RD;
         end
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Output decode from the state register only.
   always_comb begin
      bus.WE_p_mem    = 1'b0;
      bus.WE_ux_mem   = 1'b0;
      bus.WE_uy_mem   = 1'b0;
      bus.WE_fin_mem  = 1'b0;
      bus.select_init = 1'b0;
      bus.LD_EN_P     = 1'b0;
      bus.LD_EN_PUX   = 1'b0;
      bus.LD_EN_PUY   = 1'b0;
      bus.div_start   = 1'b0;
      bus.busy        = (state_q != IDLE);
      bus.done        = 1'b0;

      case (state_q)
         INIT_WR: begin
            bus.WE_p_mem    = 1'b1;
            bus.WE_ux_mem   = 1'b1;
            bus.WE_uy_mem   = 1'b1;
            bus.WE_fin_mem  = 1'b1;
            bus.select_init = 1'b1;
         end
         MOM_LD: begin
            bus.LD_EN_P   = 1'b1;
            bus.LD_EN_PUX = 1'b1;
            bus.LD_EN_PUY = 1'b1;
         end
         DIV_REQ: bus.div_start = 1'b1;
         // p is rewritten from the p register together with the velocities.
         MOM_WR: begin
            bus.WE_p_mem  = 1'b1;
            bus.WE_ux_mem = 1'b1;
            bus.WE_uy_mem = 1'b1;
         end
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.address    = address_q;
   assign bus.step_count = step_count_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lbm_step_sequencer
// Randomised bench for lbm_step_sequencer at GRID_DIM=4. A run request builds
// the full timed list of strobe events the run must produce (computed from
// the cell/step schedule with plain arithmetic) and pushes it into exp_q; an
// independent monitor pops and compares whenever the DUT shows any strobe.
// A divider responder answers each div_start after a chosen delay and may
// keep div_done high for a few extra cycles to exercise ignored div_done.
// ---------------------------------------------------------------------------
module tb_lbm_step_sequencer;

   localparam int G  = 4;
   localparam int AW = 2;
   localparam int SW = 16;
   // event = {cycle, WE p/ux/uy/fin, select_init, LD p/pux/puy, div_start, done, address, step_count}
   localparam int EW = 32 + 4 + 1 + 3 + 1 + 1 + AW + SW;
   localparam int OW = AW + 11 + SW;

   // ---------------- clock / reset ----------------
   logic Clk = 1'b0;
   logic Reset = 1'b0;
   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   lbm_step_sequencer_if #(.ADDRESS_WIDTH(AW), .STEP_WIDTH(SW)) bus ();
   logic [3:0] state_dbg;

   lbm_step_sequencer #(
      .GRID_DIM(G), .ADDRESS_WIDTH(AW), .STEP_WIDTH(SW)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .bus(bus),
      .state_dbg(state_dbg)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   int run_lo = 1;
   int run_hi = 0;

   function automatic logic [EW-1:0] mk_ev(input int c, input logic [3:0] we, input logic sel,
                                           input logic [2:0] ld, input logic ds, input logic dn,
                                           input int a, input int s);
      return {32'(c), we, sel, ld, ds, dn, AW'(a), SW'(s)};
   endfunction

   function automatic logic [OW-1:0] all_outs();
      return {bus.address, bus.WE_p_mem, bus.WE_ux_mem, bus.WE_uy_mem, bus.WE_fin_mem,
              bus.select_init, bus.LD_EN_P, bus.LD_EN_PUX, bus.LD_EN_PUY,
              bus.div_start, bus.busy, bus.done, bus.step_count};
   endfunction

   // ---------------- divider responder ----------------
   bit tie_mode = 1'b0;
   int delay_q[$];
   int pend = 0;
   int hold = 0;

   always @(negedge Clk) begin
      if (tie_mode) begin
         bus.div_done = 1'b1;
      end else if (bus.div_start === 1'b1) begin
         pend = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
         hold = 0;
         bus.div_done = 1'b0;
      end else if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            bus.div_done = 1'b1;
            hold = $urandom_range(0, 3);
         end
      end else if (hold > 0) begin
         hold--;
      end else begin
         bus.div_done = 1'b0;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge Clk) begin : monitor
      logic [EW-1:0] act;
      logic [EW-1:0] exp_ev;
      logic          exp_busy;
      act = mk_ev(cyc, {bus.WE_p_mem, bus.WE_ux_mem, bus.WE_uy_mem, bus.WE_fin_mem},
                  bus.select_init, {bus.LD_EN_P, bus.LD_EN_PUX, bus.LD_EN_PUY},
                  bus.div_start, bus.done, int'(bus.address), int'(bus.step_count));
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
         exp_ev = exp_q.pop_front();
         total++; bad++;
         $display("FAIL missed_event: no strobe seen, required %h", exp_ev);
      end
      if (|act[AW+SW +: 10]) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %h, required no strobe", act);
         end else begin
            exp_ev = exp_q.pop_front();
            if (act !== exp_ev) begin
               bad++;
               $display("FAIL event: got %h required %h", act, exp_ev);
            end
         end
      end
      exp_busy = (cyc >= run_lo) && (cyc <= run_hi);
      total++;
      if (bus.busy !== exp_busy) begin
         bad++;
         $display("FAIL busy at cycle %0d: got %b required %b (state %0d)", cyc, bus.busy, exp_busy, state_dbg);
      end
   end

   // ---------------- driver ----------------
   // glitch_off: cycle offset after start at which start is pulsed again
   // (-1 none, -2 random within the run). abort_cell: cell of the first sweep
   // whose first DIV_WAIT cycle gets a reset (-1 none).
   task automatic run_seq(input int n, input bit tie, input int fixed_w,
                          input int glitch_off, input int abort_cell);
      int c, t, w, lim, abort_cyc, goff;
      tie_mode = tie;
      @(negedge Clk);
      c = cyc;
      t = c + 1;
      abort_cyc = -1;
      for (int a = 0; a < G; a++) begin
         exp_q.push_back(mk_ev(t, 4'b1111, 1'b1, 3'b000, 1'b0, 1'b0, a, 0));
         t++;
      end
      for (int s = 0; s < n; s++) begin
         for (int a = 0; a < G; a++) begin
            if (tie) w = 1;
            else if (fixed_w > 0) w = fixed_w;
            else w = $urandom_range(1, 4);
            if (!tie) delay_q.push_back(w);
            t++;                                    // read latency slot
            exp_q.push_back(mk_ev(t, 4'b0000, 1'b0, 3'b111, 1'b0, 1'b0, a, s));
            t++;
            exp_q.push_back(mk_ev(t, 4'b0000, 1'b0, 3'b000, 1'b1, 1'b0, a, s));
            if (s == 0 && a == abort_cell) abort_cyc = t + 1;
            t = t + 1 + w;
            exp_q.push_back(mk_ev(t, 4'b1110, 1'b0, 3'b000, 1'b0, 1'b0, a, s));
            t++;
         end
         t++;                                       // sweep bookkeeping cycle
      end
      exp_q.push_back(mk_ev(t, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 0, n));
      run_lo = c + 1;
      run_hi = t;
      goff = (glitch_off == -2) ? $urandom_range(1, t - c) : glitch_off;
      bus.start     = 1'b1;
      bus.num_steps = SW'(n);
      lim = t + 20;
      while (1) begin
         @(negedge Clk);
         bus.start     = 1'b0;
         bus.num_steps = SW'($urandom);
         if (goff > 0 && cyc == c + goff) bus.start = 1'b1;
         if (cyc == abort_cyc) begin
            Reset = 1'b0;
            while (exp_q.size() > 0 && int'(exp_q[exp_q.size()-1][EW-1 -: 32]) > cyc)
               void'(exp_q.pop_back());
            delay_q.delete();
            run_hi = cyc;
         end else if (Reset == 1'b0) begin
            Reset = 1'b1;
            total++;
            if (all_outs() !== '0) begin
               bad++;
               $display("FAIL abort_reset_outputs: got %h required 0", all_outs());
            end
         end
         if (cyc > run_hi + 2) break;
         if (cyc > lim) begin
            total++; bad++;
            $display("FAIL run_timeout: cycle %0d exceeds bound %0d", cyc, lim);
            break;
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus.start     = 1'b1;     // held high through reset: must not start a run
      bus.num_steps = SW'(5);
      Reset = 1'b0;
      repeat (2) begin
         @(negedge Clk);
         total++;
         if (all_outs() !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0", all_outs());
         end
      end
      bus.start = 1'b0;
      Reset = 1'b1;
      repeat (4) @(negedge Clk);

      run_seq(1, 1'b1, 0, -1, -1);   // div_done tied high: 26 cycles start-to-done
      run_seq(0, 1'b0, 0, -1, -1);   // init only
      run_seq(2, 1'b0, 3, -1, -1);   // divider answers after 3 cycles
      run_seq(1, 1'b0, 3, -1, 2);    // reset in DIV_WAIT of cell 2
      repeat (3) @(negedge Clk);
      run_seq(2, 1'b0, 0, 5, -1);    // second start during first read slot
      for (int i = 0; i < 8; i++) begin
         run_seq($urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, -2, -1);
      end

      repeat (4) @(negedge Clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_events: got %0d pending required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
